// File: rtl/rv_pkg.sv
// Shared RV32I definitions: datapath width, NOP encoding, opcodes, ALU ops,
// immediate-format selector and the decode-stage FSM state type.
package rv_pkg;

    localparam int          XLEN      = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0,x0,0

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    // ALU op is {alt bit, funct3}; branches compare by subtraction.
    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b1000;

    typedef enum logic [1:0] {
        IMM_I = 2'd0,
        IMM_S = 2'd1,
        IMM_B = 2'd2
    } imm_sel_t;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_BUBBLE = 1'b1
    } dec_state_t;

endpackage

// File: rtl/decode_stage_imm_gen.sv
// Combinational immediate generator for the I, S and B formats.
module imm_gen
    import rv_pkg::*;
#(
    parameter int XLEN = rv_pkg::XLEN
) (
    input  logic [31:0]     instr,
    input  imm_sel_t        sel,
    output logic [XLEN-1:0] imm
);

    // Sign-extend the format-specific immediate bits from instr[31].
    always_comb begin
        imm = '0;
        case (sel)
            IMM_I:   imm = {{(XLEN-12){instr[31]}}, instr[31:20]};
            IMM_S:   imm = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm = {{(XLEN-12){instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
            default: imm = '0;
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: IF/ID register, field decode, writeback bypass,
// load-use hazard detection with a one-cycle bubble, and the ID/EX register.
//
// Handshake: InValid qualifies InstrIn/PcIn. The IF/ID register accepts them
// on a rising edge when Flush=0 and Stall=0; while Stall=1 the fetch stage
// must hold PC and re-present nothing new (the offered word is not taken).
module decode_stage
    import rv_pkg::*;
#(
    parameter int          XLEN      = rv_pkg::XLEN,
    parameter logic [31:0] NOP_INSTR = rv_pkg::NOP_INSTR
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [31:0]     InstrIn,
    input  logic [XLEN-1:0] PcIn,
    input  logic            InValid,
    input  logic            Flush,
    output logic [4:0]      ReadReg1,
    output logic [4:0]      ReadReg2,
    input  logic [XLEN-1:0] ReadData1,
    input  logic [XLEN-1:0] ReadData2,
    input  logic            WbRegWrite,
    input  logic [4:0]      WbWriteReg,
    input  logic [XLEN-1:0] WbWriteData,
    output logic            Stall,
    output logic            ExValid,
    output logic [XLEN-1:0] ExPc,
    output logic [XLEN-1:0] ExRs1Data,
    output logic [XLEN-1:0] ExRs2Data,
    output logic [XLEN-1:0] ExImm,
    output logic [4:0]      ExRd,
    output logic [4:0]      ExRs1,
    output logic [4:0]      ExRs2,
    output logic [3:0]      ExAluOp,
    output logic            ExAluSrc,
    output logic            ExMemRead,
    output logic            ExMemWrite,
    output logic            ExRegWrite,
    output logic            ExMemToReg,
    output logic            ExBranch,
    output logic            IllegalInstr,
    output dec_state_t      dbg_state
);

    logic [31:0]     ifid_instr;
    logic [XLEN-1:0] ifid_pc;
    logic            ifid_valid;
    dec_state_t      state;

    logic [6:0] opcode;
    logic [4:0] rd, rs1, rs2;
    logic [2:0] funct3;

    assign opcode = ifid_instr[6:0];
    assign rd     = ifid_instr[11:7];
    assign funct3 = ifid_instr[14:12];
    assign rs1    = ifid_instr[19:15];
    assign rs2    = ifid_instr[24:20];

    assign ReadReg1  = rs1;
    assign ReadReg2  = rs2;
    assign dbg_state = state;

    logic       legal, uses_rs2, reg_write, alu_src, mem_read, mem_write, mem_to_reg, branch;
    logic [3:0] alu_op;
    imm_sel_t   imm_sel;
    logic [XLEN-1:0] imm;

    // Opcode decode into control bits; unsupported opcodes leave everything 0.
    always_comb begin
        legal      = 1'b0;
        uses_rs2   = 1'b0;
        reg_write  = 1'b0;
        alu_src    = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_to_reg = 1'b0;
        branch     = 1'b0;
        alu_op     = ALU_ADD;
        imm_sel    = IMM_I;
        case (opcode)
            OP_R: begin
                legal     = 1'b1;
                uses_rs2  = 1'b1;
                reg_write = 1'b1;
                alu_op    = {ifid_instr[30], funct3};
            end
            OP_I: begin
                legal     = 1'b1;
                reg_write = 1'b1;
                alu_src   = 1'b1;
                // Only SRAI carries the alternate bit (imm[10]); other I-ops ignore it.
                alu_op    = {(funct3 == 3'b101) && ifid_instr[30], funct3};
            end
            OP_LOAD: begin
                legal      = 1'b1;
                reg_write  = 1'b1;
                alu_src    = 1'b1;
                mem_read   = 1'b1;
                mem_to_reg = 1'b1;
            end
            OP_STORE: begin
                legal     = 1'b1;
                uses_rs2  = 1'b1;
                alu_src   = 1'b1;
                mem_write = 1'b1;
                imm_sel   = IMM_S;
            end
            OP_BRANCH: begin
                legal    = 1'b1;
                uses_rs2 = 1'b1;
                branch   = 1'b1;
                alu_op   = ALU_SUB;
                imm_sel  = IMM_B;
            end
            default: legal = 1'b0;
        endcase
    end

    imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .instr (ifid_instr),
        .sel   (imm_sel),
        .imm   (imm)
    );

    logic [XLEN-1:0] rs1_data, rs2_data;

    // Register file writes land at the edge, so same-cycle writeback is bypassed here.
    always_comb begin
        rs1_data = ReadData1;
        rs2_data = ReadData2;
        if (rs1 == 5'd0)
            rs1_data = '0;
        else if (WbRegWrite && WbWriteReg == rs1)
            rs1_data = WbWriteData;
        if (rs2 == 5'd0)
            rs2_data = '0;
        else if (WbRegWrite && WbWriteReg == rs2)
            rs2_data = WbWriteData;
    end

    logic hazard, issue;

    assign hazard = ifid_valid && ExValid && ExMemRead && (ExRd != 5'd0) &&
                    ((ExRd == rs1) || (uses_rs2 && (ExRd == rs2)));
    assign Stall  = hazard && (state == ST_RUN);
    assign issue  = !Flush && !Stall && ifid_valid && legal;

    // IF/ID register: flush kills, stall holds, otherwise accept fetch.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ifid_instr <= NOP_INSTR;
            ifid_pc    <= '0;
            ifid_valid <= 1'b0;
        end else if (Flush) begin
            ifid_instr <= NOP_INSTR;
            ifid_pc    <= '0;
            ifid_valid <= 1'b0;
        end else if (!Stall) begin
            ifid_instr <= InstrIn;
            ifid_pc    <= PcIn;
            ifid_valid <= InValid;
        end
    end

    // ID/EX register and RUN/BUBBLE state; non-issued cycles load an all-zero bubble.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= ST_RUN;
            ExValid      <= 1'b0;
            ExPc         <= '0;
            ExRs1Data    <= '0;
            ExRs2Data    <= '0;
            ExImm        <= '0;
            ExRd         <= '0;
            ExRs1        <= '0;
            ExRs2        <= '0;
            ExAluOp      <= '0;
            ExAluSrc     <= 1'b0;
            ExMemRead    <= 1'b0;
            ExMemWrite   <= 1'b0;
            ExRegWrite   <= 1'b0;
            ExMemToReg   <= 1'b0;
            ExBranch     <= 1'b0;
            IllegalInstr <= 1'b0;
        end else begin
            case (state)
                ST_RUN:    state <= (Stall && !Flush) ? ST_BUBBLE : ST_RUN;
                ST_BUBBLE: state <= ST_RUN;
                default:   state <= ST_RUN;
            endcase
            ExValid      <= issue;
            ExPc         <= issue ? ifid_pc : '0;
            ExRs1Data    <= issue ? rs1_data : '0;
            ExRs2Data    <= (issue && uses_rs2) ? rs2_data : '0;
            ExImm        <= (issue && opcode != OP_R) ? imm : '0;
            ExRd         <= (issue && reg_write) ? rd : 5'd0;
            ExRs1        <= issue ? rs1 : 5'd0;
            ExRs2        <= (issue && uses_rs2) ? rs2 : 5'd0;
            ExAluOp      <= issue ? alu_op : 4'd0;
            ExAluSrc     <= issue && alu_src;
            ExMemRead    <= issue && mem_read;
            ExMemWrite   <= issue && mem_write;
            ExRegWrite   <= issue && reg_write;
            ExMemToReg   <= issue && mem_to_reg;
            ExBranch     <= issue && branch;
            IllegalInstr <= !Flush && !Stall && ifid_valid && !legal;
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed spec scenarios followed by random traffic,
// all checked against an instruction-level reference model.
module tb_decode_stage;
    import rv_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] InstrIn, PcIn;
    logic        InValid, Flush;
    logic [4:0]  ReadReg1, ReadReg2;
    logic [31:0] ReadData1, ReadData2;
    logic        WbRegWrite;
    logic [4:0]  WbWriteReg;
    logic [31:0] WbWriteData;
    logic        Stall, ExValid;
    logic [31:0] ExPc, ExRs1Data, ExRs2Data, ExImm;
    logic [4:0]  ExRd, ExRs1, ExRs2;
    logic [3:0]  ExAluOp;
    logic        ExAluSrc, ExMemRead, ExMemWrite, ExRegWrite, ExMemToReg, ExBranch;
    logic        IllegalInstr;
    dec_state_t  dbg_state;

    always #5 clock = ~clock;

    decode_stage dut (
        .clock(clock), .reset(reset), .InstrIn(InstrIn), .PcIn(PcIn),
        .InValid(InValid), .Flush(Flush), .ReadReg1(ReadReg1), .ReadReg2(ReadReg2),
        .ReadData1(ReadData1), .ReadData2(ReadData2), .WbRegWrite(WbRegWrite),
        .WbWriteReg(WbWriteReg), .WbWriteData(WbWriteData), .Stall(Stall),
        .ExValid(ExValid), .ExPc(ExPc), .ExRs1Data(ExRs1Data), .ExRs2Data(ExRs2Data),
        .ExImm(ExImm), .ExRd(ExRd), .ExRs1(ExRs1), .ExRs2(ExRs2), .ExAluOp(ExAluOp),
        .ExAluSrc(ExAluSrc), .ExMemRead(ExMemRead), .ExMemWrite(ExMemWrite),
        .ExRegWrite(ExRegWrite), .ExMemToReg(ExMemToReg), .ExBranch(ExBranch),
        .IllegalInstr(IllegalInstr), .dbg_state(dbg_state)
    );

    // Register file model; x0 deliberately holds garbage to prove the DUT forces 0.
    logic [31:0] regs [32];
    assign ReadData1 = regs[ReadReg1];
    assign ReadData2 = regs[ReadReg2];

    typedef struct packed {
        logic        valid;
        logic [31:0] pc, rs1_data, rs2_data, imm;
        logic [4:0]  rd, rs1, rs2;
        logic [3:0]  alu_op;
        logic        alu_src, mem_read, mem_write, reg_write, mem_to_reg, branch;
    } ex_t;

    logic [31:0] m_if_instr, m_if_pc;
    logic        m_if_valid, m_ill, m_bubble;
    ex_t         m_ex;
    int          n_vec = 0;
    int          n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int sext12(input int v);
        return (v >= 2048) ? v - 4096 : v;
    endfunction

    function automatic logic has_rs2(input logic [31:0] i);
        return i[6:0] == OP_R || i[6:0] == OP_STORE || i[6:0] == OP_BRANCH;
    endfunction

    function automatic logic is_legal(input logic [31:0] i);
        return i[6:0] == OP_R || i[6:0] == OP_I || i[6:0] == OP_LOAD ||
               i[6:0] == OP_STORE || i[6:0] == OP_BRANCH;
    endfunction

    // Architectural read as seen in decode: x0 is zero, pending writeback wins.
    function automatic logic [31:0] ref_read(input logic [4:0] idx);
        if (idx == 5'd0) return 32'd0;
        if (WbRegWrite && WbWriteReg == idx) return WbWriteData;
        return regs[idx];
    endfunction

    function automatic ex_t ref_decode(input logic [31:0] i, input logic [31:0] pc);
        ex_t        e;
        int         imm;
        logic [2:0] f3;
        e   = '0;
        imm = 0;
        f3  = i[14:12];
        e.valid    = 1'b1;
        e.pc       = pc;
        e.rs1      = i[19:15];
        e.rs1_data = ref_read(i[19:15]);
        case (i[6:0])
            OP_R: begin
                e.rs2 = i[24:20]; e.rs2_data = ref_read(i[24:20]);
                e.rd = i[11:7]; e.reg_write = 1'b1; e.alu_op = {i[30], f3};
            end
            OP_I: begin
                imm = sext12(int'(i[31:20]));
                e.rd = i[11:7]; e.reg_write = 1'b1; e.alu_src = 1'b1;
                e.alu_op = (f3 == 3'd5) ? {i[30], f3} : {1'b0, f3};
            end
            OP_LOAD: begin
                imm = sext12(int'(i[31:20]));
                e.rd = i[11:7]; e.reg_write = 1'b1; e.alu_src = 1'b1;
                e.mem_read = 1'b1; e.mem_to_reg = 1'b1;
            end
            OP_STORE: begin
                imm = sext12(int'(i[31:25]) * 32 + int'(i[11:7]));
                e.rs2 = i[24:20]; e.rs2_data = ref_read(i[24:20]);
                e.alu_src = 1'b1; e.mem_write = 1'b1;
            end
            OP_BRANCH: begin
                imm = int'(i[7]) * 2048 + int'(i[30:25]) * 32 + int'(i[11:8]) * 2 -
                      (i[31] ? 4096 : 0);
                e.rs2 = i[24:20]; e.rs2_data = ref_read(i[24:20]);
                e.branch = 1'b1; e.alu_op = 4'b1000;
            end
            default: return '0;
        endcase
        e.imm = imm;
        return e;
    endfunction

    function automatic logic model_stall();
        return m_if_valid && m_ex.valid && m_ex.mem_read && m_ex.rd != 5'd0 &&
               (m_ex.rd == m_if_instr[19:15] ||
                (has_rs2(m_if_instr) && m_ex.rd == m_if_instr[24:20]));
    endfunction

    task automatic model_reset();
        m_if_instr = 32'h13; m_if_pc = '0; m_if_valid = 1'b0;
        m_ex = '0; m_ill = 1'b0; m_bubble = 1'b0;
    endtask

    task automatic check_all();
        chk("read_reg1", 32'(ReadReg1), 32'(m_if_instr[19:15]));
        chk("read_reg2", 32'(ReadReg2), 32'(m_if_instr[24:20]));
        chk("stall", 32'(Stall), 32'(model_stall()));
        chk("ex_valid", 32'(ExValid), 32'(m_ex.valid));
        chk("ex_pc", ExPc, m_ex.pc);
        chk("ex_rs1_data", ExRs1Data, m_ex.rs1_data);
        chk("ex_rs2_data", ExRs2Data, m_ex.rs2_data);
        chk("ex_imm", ExImm, m_ex.imm);
        chk("ex_rd", 32'(ExRd), 32'(m_ex.rd));
        chk("ex_rs1", 32'(ExRs1), 32'(m_ex.rs1));
        chk("ex_rs2", 32'(ExRs2), 32'(m_ex.rs2));
        chk("ex_alu_op", 32'(ExAluOp), 32'(m_ex.alu_op));
        chk("ex_alu_src", 32'(ExAluSrc), 32'(m_ex.alu_src));
        chk("ex_mem_read", 32'(ExMemRead), 32'(m_ex.mem_read));
        chk("ex_mem_write", 32'(ExMemWrite), 32'(m_ex.mem_write));
        chk("ex_reg_write", 32'(ExRegWrite), 32'(m_ex.reg_write));
        chk("ex_mem_to_reg", 32'(ExMemToReg), 32'(m_ex.mem_to_reg));
        chk("ex_branch", 32'(ExBranch), 32'(m_ex.branch));
        chk("illegal", 32'(IllegalInstr), 32'(m_ill));
        chk("fsm_bubble", 32'(dbg_state), 32'(m_bubble));
    endtask

    // Predict the next edge from current inputs, then let the edge happen.
    task automatic advance();
        logic [31:0] n_instr, n_pc;
        logic        n_valid, n_ill, n_bub;
        ex_t         n_ex;
        n_instr = m_if_instr; n_pc = m_if_pc; n_valid = m_if_valid;
        n_ex = '0; n_ill = 1'b0; n_bub = 1'b0;
        if (Flush) begin
            n_instr = 32'h13; n_pc = '0; n_valid = 1'b0;
        end else if (model_stall()) begin
            n_bub = 1'b1;
        end else begin
            n_instr = InstrIn; n_pc = PcIn; n_valid = InValid;
            n_ill = m_if_valid && !is_legal(m_if_instr);
            n_ex  = m_if_valid ? ref_decode(m_if_instr, m_if_pc) : '0;
        end
        @(posedge clock);
        #1;
        m_if_instr = n_instr; m_if_pc = n_pc; m_if_valid = n_valid;
        m_ex = n_ex; m_ill = n_ill; m_bubble = n_bub;
        if (WbRegWrite && WbWriteReg != 5'd0) regs[WbWriteReg] = WbWriteData;
    endtask

    task automatic drive(input logic [31:0] instr, input logic [31:0] pc, input logic v,
                         input logic fl, input logic we, input logic [4:0] wr,
                         input logic [31:0] wd);
        @(negedge clock);
        InstrIn = instr; PcIn = pc; InValid = v; Flush = fl;
        WbRegWrite = we; WbWriteReg = wr; WbWriteData = wd;
        #1;
        check_all();
        advance();
    endtask

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, OP_R};
    endfunction

    function automatic logic [31:0] enc_i(input logic [6:0] op, input logic [2:0] f3,
                                          input logic [4:0] rd, input logic [4:0] rs1,
                                          input int imm);
        logic [11:0] im;
        im = imm[11:0];
        return {im, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_s(input logic [4:0] rs2, input logic [4:0] rs1,
                                          input int imm);
        logic [11:0] im;
        im = imm[11:0];
        return {im[11:5], rs2, rs1, 3'b010, im[4:0], OP_STORE};
    endfunction

    function automatic logic [31:0] enc_b(input logic [2:0] f3, input logic [4:0] rs1,
                                          input logic [4:0] rs2, input int imm);
        logic [12:0] im;
        im = imm[12:0];
        return {im[12], im[10:5], rs2, rs1, f3, im[4:1], im[11], OP_BRANCH};
    endfunction

    function automatic logic [4:0] rnd_reg();
        return 5'($urandom_range(0, 7));
    endfunction

    function automatic logic [31:0] rnd_instr();
        logic [31:0] w;
        case ($urandom_range(0, 6))
            0: w = enc_r($urandom_range(0, 1) ? 7'h20 : 7'h00, rnd_reg(), rnd_reg(),
                         3'($urandom_range(0, 7)), rnd_reg());
            1: w = enc_i(OP_I, 3'($urandom_range(0, 7)), rnd_reg(), rnd_reg(),
                         int'($urandom_range(0, 4095)));
            2, 6: w = enc_i(OP_LOAD, 3'b010, rnd_reg(), rnd_reg(),
                            int'($urandom_range(0, 4095)));
            3: w = enc_s(rnd_reg(), rnd_reg(), int'($urandom_range(0, 4095)));
            4: w = enc_b(3'($urandom_range(0, 7)), rnd_reg(), rnd_reg(),
                         int'($urandom_range(0, 8191)));
            default: begin
                w = $urandom;
                w[6:0] = $urandom_range(0, 1) ? 7'h7F : 7'h37;
            end
        endcase
        return w;
    endfunction

    initial begin
        logic [31:0] lw_x6, add_x7;
        reset = 1'b1;
        InstrIn = '0; PcIn = '0; InValid = 1'b0; Flush = 1'b0;
        WbRegWrite = 1'b0; WbWriteReg = '0; WbWriteData = '0;
        for (int i = 0; i < 32; i++) regs[i] = $urandom;
        regs[0] = 32'hDEAD_BEEF;
        regs[1] = 32'd10;
        model_reset();
        repeat (3) @(posedge clock);

        // Reset state with InValid=0.
        @(negedge clock);
        reset = 1'b0;
        #1;
        check_all();
        chk("rst_stall", 32'(Stall), 32'd0);
        chk("rst_read_reg1", 32'(ReadReg1), 32'd0);
        advance();

        // addi x5,x1,-4 with x1=10.
        drive(32'hFFC0_8293, 32'h100, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        drive(32'h13, 32'h104, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        chk("addi_imm", ExImm, 32'hFFFF_FFFC);
        chk("addi_rd", 32'(ExRd), 32'd5);
        chk("addi_alu_src", 32'(ExAluSrc), 32'd1);
        chk("addi_reg_write", 32'(ExRegWrite), 32'd1);
        chk("addi_rs1_data", ExRs1Data, 32'd10);

        // add x3,x1,x2 decoded while WB writes x1=0x55.
        drive(enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd3), 32'h108, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        drive(32'h13, 32'h10C, 1'b0, 1'b0, 1'b1, 5'd1, 32'h55);
        chk("bypass_rs1", ExRs1Data, 32'h55);

        // lw x6,0(x2) then add x7,x6,x6: one stall cycle, bubble, then add.
        lw_x6  = enc_i(OP_LOAD, 3'b010, 5'd6, 5'd2, 0);
        add_x7 = enc_r(7'h00, 5'd6, 5'd6, 3'd0, 5'd7);
        drive(lw_x6, 32'h300, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        drive(add_x7, 32'h304, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        chk("lu_stall", 32'(Stall), 32'd1);
        drive(32'h13, 32'h308, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        chk("lu_stall_clear", 32'(Stall), 32'd0);
        chk("lu_bubble", 32'(ExValid), 32'd0);
        drive(32'h13, 32'h30C, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        chk("lu_add_valid", 32'(ExValid), 32'd1);
        chk("lu_add_rd", 32'(ExRd), 32'd7);

        // beq -8 stalled behind a load, then Flush during the stall.
        drive(enc_i(OP_LOAD, 3'b010, 5'd8, 5'd1, 4), 32'h400, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        drive(enc_b(3'd0, 5'd8, 5'd0, -8), 32'h404, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        chk("br_stall", 32'(Stall), 32'd1);
        drive(32'h0020_81B3, 32'h408, 1'b1, 1'b1, 1'b0, 5'd0, 32'd0);
        chk("flush_ex_valid", 32'(ExValid), 32'd0);
        chk("flush_stall", 32'(Stall), 32'd0);
        chk("flush_nop_rs1", 32'(ReadReg1), 32'd0);
        chk("flush_nop_rs2", 32'(ReadReg2), 32'd0);

        // Unstalled beq -8 immediate.
        drive(enc_b(3'd0, 5'd1, 5'd2, -8), 32'h500, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        drive(32'h13, 32'h504, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        chk("beq_imm", ExImm, 32'hFFFF_FFF8);
        chk("beq_branch", 32'(ExBranch), 32'd1);

        // Illegal opcode pulses IllegalInstr for one cycle.
        drive(32'h0000_007F, 32'h600, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        drive(32'h13, 32'h604, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        chk("illegal_set", 32'(IllegalInstr), 32'd1);
        chk("illegal_no_valid", 32'(ExValid), 32'd0);
        drive(32'h13, 32'h608, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        chk("illegal_clear", 32'(IllegalInstr), 32'd0);

        // WB to x0 with data 7 must not leak into x0 reads.
        drive(enc_r(7'h00, 5'd0, 5'd0, 3'd0, 5'd9), 32'h700, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        drive(32'h13, 32'h704, 1'b0, 1'b0, 1'b1, 5'd0, 32'd7);
        chk("x0_rs1", ExRs1Data, 32'd0);
        chk("x0_rs2", ExRs2Data, 32'd0);

        // Reset asserted in the middle of a load-use stall.
        drive(lw_x6, 32'h800, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        drive(add_x7, 32'h804, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        chk("mid_stall", 32'(Stall), 32'd1);
        @(negedge clock);
        reset = 1'b1;
        #1;
        model_reset();
        check_all();
        @(negedge clock);
        reset = 1'b0; InValid = 1'b0; Flush = 1'b0; WbRegWrite = 1'b0;
        #1;
        check_all();
        advance();

        // Random traffic.
        for (int n = 0; n < 300; n++) begin
            drive(rnd_instr(), 32'($urandom) & 32'hFFFF_FFFC,
                  $urandom_range(0, 9) != 0, $urandom_range(0, 19) == 0,
                  $urandom_range(0, 1) == 1, rnd_reg(), $urandom);
        end
        drive(32'h13, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
